// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then 8 data bits + odd parity + stop on device clocks.
// Define PS2_TX_ACK_CHECK_EN to abort with err_code=2 when the device does not ACK on the 11th falling edge.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES     = 12000,
  parameter int REQ_TIMEOUT_CYCLES = 1500000,
  parameter int BIT_TIMEOUT_CYCLES = 200000,
  parameter int SYNC_STAGES        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int MAX_AB = (INHIBIT_CYCLES > REQ_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : REQ_TIMEOUT_CYCLES;
  localparam int MAX_P  = (MAX_AB > BIT_TIMEOUT_CYCLES) ? MAX_AB : BIT_TIMEOUT_CYCLES;
  localparam int CW     = $clog2(MAX_P + 1);
  localparam logic [CW-1:0] INH_LIM = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] REQ_LIM = CW'(REQ_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] BIT_LIM = CW'(BIT_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic [CW-1:0]          cnt_q, cnt_inc;
  logic [9:0]             shreg_q;
  logic [3:0]             bit_cnt_q;
  logic                   tx_ready_q, busy_q, done_q, err_q, clk_oe_q, data_oe_q;
  logic [1:0]             err_code_q;
  logic                   clk_s, data_s, fall, in_xfer, timeout, nack;
  logic [CW-1:0]          lim;

  // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_s;
    end
  end

  assign clk_s   = clk_sync_q[SYNC_STAGES-1];
  assign data_s  = data_sync_q[SYNC_STAGES-1];
  assign fall    = clk_prev_q & ~clk_s;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign in_xfer = (state_q == REQ) || (state_q == SHIFT) || (state_q == ACK) || (state_q == WAIT_IDLE);

  always_comb begin
    lim     = (state_q == REQ) ? REQ_LIM : BIT_LIM;
    timeout = in_xfer && !fall && (cnt_q >= lim) &&
              !((state_q == WAIT_IDLE) && clk_s && data_s);
`ifdef PS2_TX_ACK_CHECK_EN
    nack    = (state_q == ACK) && fall && data_s;
`else
    nack    = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // Edges during INHIBIT are our own pull-down, so they must not restart the count.
      cnt_q  <= (fall && state_q != INHIBIT) ? '0 : cnt_inc;
      if (timeout || nack) begin
        err_q      <= 1'b1;
        err_code_q <= nack ? 2'd2 : ((state_q == REQ) ? 2'd0 : 2'd1);
        clk_oe_q   <= 1'b0;
        data_oe_q  <= 1'b0;
        busy_q     <= 1'b0;
        tx_ready_q <= 1'b1;
        state_q    <= IDLE;
        cnt_q      <= '0;
      end else begin
        case (state_q)
          IDLE: if (tx_valid && tx_ready_q) begin
            shreg_q    <= {1'b1, ~^tx_data, tx_data};
            clk_oe_q   <= 1'b1;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b1;
            tx_ready_q <= 1'b0;
            state_q    <= INHIBIT;
            cnt_q      <= '0;
          end
          INHIBIT: if (cnt_q >= INH_LIM) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b1;
            state_q   <= REQ;
            cnt_q     <= '0;
          end
          REQ: if (fall) begin
            data_oe_q <= ~shreg_q[0];
            shreg_q   <= shreg_q >> 1;
            bit_cnt_q <= 4'd1;
            state_q   <= SHIFT;
          end
          SHIFT: if (fall) begin
            data_oe_q <= ~shreg_q[0];
            shreg_q   <= shreg_q >> 1;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd9) state_q <= ACK;
          end
          ACK: if (fall) state_q <= WAIT_IDLE;
          WAIT_IDLE: if (clk_s && data_s) begin
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tx_ready    = tx_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
endmodule
